cfu_seq: RTL and testbench
==========================

Name: cfu_seq

Overview:
Second-generation Tiny86 control flow unit: computes next EIP for sequential flow, Jcc/JCXZ, relative/absolute JMP/CALL, RET, and the LOOP/LOOPE/LOOPNE family, with the ECX decrement these imply. Adds a parametrised return-address stack (RAS) that checks RET targets, a valid/ready handshake on both sides, and one registered output stage. Sits between decode/operand fetch and the EIP/ECX writeback in the execute stage.

Parameters:
ADDR_W, 32, width of eip, address, ecx, next_eip, ecx_out
LEN_W, 4, width of instr_len
RAS_DEPTH, 8, RAS entries; power of two, >= 2

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  command valid
in_ready  output  1  command accepted when in_valid & in_ready
opc  input  7  command index (CMD_* encoding)
eflags  input  32  EFLAGS (CF, PF, ZF, SF, OF used)
ecx  input  ADDR_W  current ECX
eip  input  ADDR_W  current EIP
instr_len  input  LEN_W  instruction length in bytes
address  input  ADDR_W  relative displacement or absolute target (RET: popped return address)
flush  input  1  synchronous pipeline flush
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
next_eip  output  ADDR_W  next EIP
ecx_out  output  ADDR_W  new ECX value
ecx_we  output  1  ecx_out must be written back
ras_hit  output  1  RET target matched RAS prediction
ras_miss  output  1  RET target mismatched or RAS empty

Behaviour:
- Reset (rst_n low, async): out_valid, next_eip, ecx_out, ecx_we, ras_hit, ras_miss = 0; RAS pointer and count = 0.
- in_ready = !out_valid | out_ready (combinational). Latency: accept at edge N, result visible with out_valid=1 after edge N; full throughput of one command per cycle.
- While out_valid & !out_ready, all outputs and the RAS hold stable.
- seq_eip = eip + zero-extended instr_len, modulo 2^ADDR_W. Relative target = seq_eip + address, modulo 2^ADDR_W.
- Jcc conditions (JO..JG) are standard x86 semantics on eflags. JCXZ is taken when ecx == 0; no ECX write. All are relative.
- LOOP: dec = ecx - 1 (0 wraps to all-ones); taken if dec != 0. LOOPE: taken if dec != 0 & ZF. LOOPNE: taken if dec != 0 & !ZF. ecx_we = 1 and ecx_out = dec whether or not the branch is taken. All three are relative.
- JMPr and CALLr are relative. JMPi, CALLi and RET are absolute: next_eip = address.
- Not-taken branches and all other commands: next_eip = seq_eip, ecx_we = 0.
- RAS push on CALLr/CALLi: the entry stores seq_eip. count saturates at RAS_DEPTH; a push when full overwrites the oldest entry (circular).
- RAS pop on RET:
  - count > 0: pop the top entry. ras_hit = (top == address); ras_miss = !ras_hit.
  - count == 0: ras_miss = 1, ras_hit = 0, count stays 0.
- For non-RET commands, ras_hit = ras_miss = 0.
- flush: at the next edge, out_valid is cleared and the RAS count/pointer reset to 0.
  - flush with a simultaneous accept: flush wins. The command is discarded and there is no RAS update.
  - flush has priority over a stalled output.
- Reset asserted mid-stall drops the pending result immediately.

Test Plan:
- Reset, then opc=MOV, eip=0x1000, instr_len=3, out_ready=1 -> one cycle later out_valid=1, next_eip=0x1003, ecx_we=0.
- JE with ZF=1, eip=0x2000, instr_len=2, address=0xFFFFFFF0 -> next_eip=0x1FF2; same command with ZF=0 -> 0x2002.
- LOOP with ecx=1, eip=0x3000, len=2, address=0x10 -> ecx_out=0, ecx_we=1, next_eip=0x3002. LOOP with ecx=0 -> ecx_out=0xFFFFFFFF, branch taken to 0x3012. LOOPNE with ecx=5, ZF=1 -> not taken, ecx_out=4.
- CALLi at eip=0x4000, len=5, address=0x8000 -> next_eip=0x8000. RET with address=0x4005 -> ras_hit=1. Second RET -> ras_miss=1 (RAS empty).
- Nine CALLs with RAS_DEPTH=8, then nine RETs with correct targets -> first eight give ras_hit, ninth gives ras_miss.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs stable. Assert flush together with in_valid -> out_valid=0 next cycle, RAS empty, command dropped.

Source files
------------

// File: rtl/cfu_seq.sv
// Control flow unit: next-EIP for sequential/Jcc/JCXZ/LOOPcc/JMP/CALL/RET, ECX decrement, RET-checking return-address stack.
// Latency: one cycle; a command accepted at edge N has its result on the outputs with out_valid=1 after edge N.
// Backpressure: in_ready = !out_valid | out_ready; while out_valid & !out_ready the outputs and RAS hold.
//
// Ports: clk/rst_n (async active-low); in_valid/in_ready command handshake carrying opc, eflags, ecx,
// eip, instr_len, address; flush drops the pending result and empties the RAS; out_valid/out_ready
// result handshake carrying next_eip, ecx_out, ecx_we, ras_hit, ras_miss.
module cfu_seq #(
  parameter int ADDR_W    = 32,
  parameter int LEN_W     = 4,
  parameter int RAS_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opc,
  input  logic [31:0]       eflags,
  input  logic [ADDR_W-1:0] ecx,
  input  logic [ADDR_W-1:0] eip,
  input  logic [LEN_W-1:0]  instr_len,
  input  logic [ADDR_W-1:0] address,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] next_eip,
  output logic [ADDR_W-1:0] ecx_out,
  output logic              ecx_we,
  output logic              ras_hit,
  output logic              ras_miss
);

  // Command encoding; any opc not listed is a plain sequential instruction.
  localparam logic [6:0] CMD_JO = 7'd0,  CMD_JNO = 7'd1,  CMD_JB  = 7'd2,  CMD_JAE = 7'd3;
  localparam logic [6:0] CMD_JE = 7'd4,  CMD_JNE = 7'd5,  CMD_JBE = 7'd6,  CMD_JA  = 7'd7;
  localparam logic [6:0] CMD_JS = 7'd8,  CMD_JNS = 7'd9,  CMD_JP  = 7'd10, CMD_JNP = 7'd11;
  localparam logic [6:0] CMD_JL = 7'd12, CMD_JGE = 7'd13, CMD_JLE = 7'd14, CMD_JG  = 7'd15;
  localparam logic [6:0] CMD_JCXZ = 7'd16, CMD_LOOP = 7'd17, CMD_LOOPE = 7'd18, CMD_LOOPNE = 7'd19;
  localparam logic [6:0] CMD_JMPR = 7'd20, CMD_JMPI = 7'd21, CMD_CALLR = 7'd22, CMD_CALLI = 7'd23;
  localparam logic [6:0] CMD_RET  = 7'd24;

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  ras_ptr;   // next free slot; top of stack is ras_ptr-1
  logic [CNT_W-1:0]  ras_cnt;

  logic cf, pf, zf, sf, of;
  logic [ADDR_W-1:0] seq_eip, rel_eip, dec, top, nxt;
  logic taken_rel, taken_abs, loop_cmd, is_call, is_ret, accept;

  assign cf = eflags[0];
  assign pf = eflags[2];
  assign zf = eflags[6];
  assign sf = eflags[7];
  assign of = eflags[11];

  assign seq_eip = eip + {{(ADDR_W-LEN_W){1'b0}}, instr_len};
  assign rel_eip = seq_eip + address;
  assign dec     = ecx - ADDR_W'(1);
  assign top     = ras_mem[ras_ptr - PTR_W'(1)];

  assign in_ready = !out_valid | out_ready;
  assign accept   = in_valid & in_ready & !flush;
  assign is_call  = (opc == CMD_CALLR) | (opc == CMD_CALLI);
  assign is_ret   = (opc == CMD_RET);

  always_comb begin
    taken_rel = 1'b0;
    taken_abs = 1'b0;
    loop_cmd  = 1'b0;
    case (opc)
      CMD_JO:     taken_rel = of;
      CMD_JNO:    taken_rel = !of;
      CMD_JB:     taken_rel = cf;
      CMD_JAE:    taken_rel = !cf;
      CMD_JE:     taken_rel = zf;
      CMD_JNE:    taken_rel = !zf;
      CMD_JBE:    taken_rel = cf | zf;
      CMD_JA:     taken_rel = !cf & !zf;
      CMD_JS:     taken_rel = sf;
      CMD_JNS:    taken_rel = !sf;
      CMD_JP:     taken_rel = pf;
      CMD_JNP:    taken_rel = !pf;
      CMD_JL:     taken_rel = sf ^ of;
      CMD_JGE:    taken_rel = !(sf ^ of);
      CMD_JLE:    taken_rel = zf | (sf ^ of);
      CMD_JG:     taken_rel = !zf & !(sf ^ of);
      CMD_JCXZ:   taken_rel = (ecx == '0);
      CMD_LOOP:   begin loop_cmd = 1'b1; taken_rel = (dec != '0);        end
      CMD_LOOPE:  begin loop_cmd = 1'b1; taken_rel = (dec != '0) & zf;  end
      CMD_LOOPNE: begin loop_cmd = 1'b1; taken_rel = (dec != '0) & !zf; end
      CMD_JMPR, CMD_CALLR:           taken_rel = 1'b1;
      CMD_JMPI, CMD_CALLI, CMD_RET:  taken_abs = 1'b1;
      default: ;
    endcase
    nxt = taken_abs ? address : (taken_rel ? rel_eip : seq_eip);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      next_eip  <= '0;
      ecx_out   <= '0;
      ecx_we    <= 1'b0;
      ras_hit   <= 1'b0;
      ras_miss  <= 1'b0;
      ras_ptr   <= '0;
      ras_cnt   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      ras_ptr   <= '0;
      ras_cnt   <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        next_eip <= nxt;
        ecx_out  <= loop_cmd ? dec : ecx;
        ecx_we   <= loop_cmd;
        ras_hit  <= 1'b0;
        ras_miss <= 1'b0;
        if (is_call) begin
          // Full stack wraps over its oldest entry; count saturates.
          ras_ptr <= ras_ptr + PTR_W'(1);
          if (ras_cnt != CNT_W'(RAS_DEPTH)) ras_cnt <= ras_cnt + CNT_W'(1);
        end else if (is_ret) begin
          if (ras_cnt != '0) begin
            ras_ptr  <= ras_ptr - PTR_W'(1);
            ras_cnt  <= ras_cnt - CNT_W'(1);
            ras_hit  <= (top == address);
            ras_miss <= (top != address);
          end else begin
            ras_miss <= 1'b1;
          end
        end
      end
    end
  end

  // Entries carry no reset: only the pointer/count define which are live.
  always_ff @(posedge clk) begin
    if (accept && is_call) ras_mem[ras_ptr] <= seq_eip;
  end

endmodule

// File: tb/tb_cfu_seq.sv
module tb_cfu_seq;

  localparam logic [6:0] JE = 7'd4, JBE = 7'd6, JA = 7'd7, JP = 7'd10, JL = 7'd12, JG = 7'd15;
  localparam logic [6:0] JCXZ = 7'd16, LOOP = 7'd17, LOOPE = 7'd18, LOOPNE = 7'd19;
  localparam logic [6:0] JMPR = 7'd20, JMPI = 7'd21, CALLR = 7'd22, CALLI = 7'd23, RET = 7'd24;
  localparam logic [6:0] MOV = 7'd40;
  localparam logic [31:0] F_CF = 32'h1, F_PF = 32'h4, F_ZF = 32'h40, F_SF = 32'h80, F_OF = 32'h800;

  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_ready, flush = 0, out_valid, out_ready = 1;
  logic [6:0]  opc = '0;
  logic [31:0] eflags = '0, ecx = '0, eip = '0, address = '0;
  logic [3:0]  instr_len = '0;
  logic [31:0] next_eip, ecx_out;
  logic ecx_we, ras_hit, ras_miss;

  int n_cmp = 0, n_err = 0;

  cfu_seq #(.ADDR_W(32), .LEN_W(4), .RAS_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .opc(opc),
    .eflags(eflags), .ecx(ecx), .eip(eip), .instr_len(instr_len), .address(address),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .next_eip(next_eip),
    .ecx_out(ecx_out), .ecx_we(ecx_we), .ras_hit(ras_hit), .ras_miss(ras_miss)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one command at the negedge, let it be accepted at the posedge, sample #1 later.
  task automatic send(input logic [6:0] o, input logic [31:0] fl, input logic [31:0] c,
                      input logic [31:0] e, input logic [3:0] l, input logic [31:0] a);
    @(negedge clk);
    opc = o; eflags = fl; ecx = c; eip = e; instr_len = l; address = a; in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  typedef struct {
    string       name;
    logic [6:0]  opc;
    logic [31:0] fl, ecx, eip;
    logic [3:0]  len;
    logic [31:0] addr, exp_eip, exp_ecx;
    logic        exp_we;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{"mov",        MOV,    0,           0,  32'h1000, 3, 0,            32'h1003,     0,            0});
    vecs.push_back('{"je_taken",   JE,     F_ZF,        0,  32'h2000, 2, 32'hFFFFFFF0, 32'h1FF2,     0,            0});
    vecs.push_back('{"je_not",     JE,     0,           0,  32'h2000, 2, 32'hFFFFFFF0, 32'h2002,     0,            0});
    vecs.push_back('{"loop_ecx1",  LOOP,   0,           1,  32'h3000, 2, 32'h10,       32'h3002,     0,            1});
    vecs.push_back('{"loop_ecx0",  LOOP,   0,           0,  32'h3000, 2, 32'h10,       32'h3012,     32'hFFFFFFFF, 1});
    vecs.push_back('{"loopne_zf",  LOOPNE, F_ZF,        5,  32'h3000, 2, 32'h10,       32'h3002,     4,            1});
    vecs.push_back('{"loope_zf",   LOOPE,  F_ZF,        5,  32'h3000, 2, 32'h10,       32'h3012,     4,            1});
    vecs.push_back('{"jcxz_taken", JCXZ,   0,           0,  32'h500,  2, 32'h20,       32'h522,      0,            0});
    vecs.push_back('{"jcxz_not",   JCXZ,   0,           7,  32'h500,  2, 32'h20,       32'h502,      0,            0});
    vecs.push_back('{"jl_taken",   JL,     F_SF,        0,  32'h600,  2, 32'h4,        32'h606,      0,            0});
    vecs.push_back('{"jl_not",     JL,     F_SF | F_OF, 0,  32'h600,  2, 32'h4,        32'h602,      0,            0});
    vecs.push_back('{"jg_taken",   JG,     0,           0,  32'h600,  2, 32'h4,        32'h606,      0,            0});
    vecs.push_back('{"jbe_cf",     JBE,    F_CF,        0,  32'h600,  2, 32'h4,        32'h606,      0,            0});
    vecs.push_back('{"ja_cf",      JA,     F_CF,        0,  32'h600,  2, 32'h4,        32'h602,      0,            0});
    vecs.push_back('{"jmpr_wrap",  JMPR,   0,           0,  32'hFFFFFFFE, 4, 32'h10,   32'h12,       0,            0});
    vecs.push_back('{"jmpi",       JMPI,   0,           0,  32'h700,  3, 32'hDEAD0000, 32'hDEAD0000, 0,            0});
    vecs.push_back('{"jp_taken",   JP,     F_PF,        0,  32'h700,  1, 32'h100,      32'h801,      0,            0});

    // Reset state
    #12;
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_next_eip", next_eip, 0);
    chk("rst_ecx_out", ecx_out, 0);
    chk("rst_flags", {28'b0, ecx_we, ras_hit, ras_miss, in_ready}, 32'h1);
    rst_n = 1;

    // Table-driven vectors
    foreach (vecs[i]) begin
      send(vecs[i].opc, vecs[i].fl, vecs[i].ecx, vecs[i].eip, vecs[i].len, vecs[i].addr);
      chk({vecs[i].name, "_valid"}, {31'b0, out_valid}, 1);
      chk({vecs[i].name, "_eip"}, next_eip, vecs[i].exp_eip);
      chk({vecs[i].name, "_we"}, {31'b0, ecx_we}, {31'b0, vecs[i].exp_we});
      if (vecs[i].exp_we) chk({vecs[i].name, "_ecx"}, ecx_out, vecs[i].exp_ecx);
      chk({vecs[i].name, "_ras"}, {30'b0, ras_hit, ras_miss}, 0);
    end

    // CALLi / RET hit / RET on empty stack
    send(CALLI, 0, 0, 32'h4000, 5, 32'h8000);
    chk("calli_eip", next_eip, 32'h8000);
    send(RET, 0, 0, 32'h8000, 1, 32'h4005);
    chk("ret1_eip", next_eip, 32'h4005);
    chk("ret1_hitmiss", {30'b0, ras_hit, ras_miss}, 32'h2);
    send(RET, 0, 0, 32'h8000, 1, 32'h4005);
    chk("ret2_hitmiss", {30'b0, ras_hit, ras_miss}, 32'h1);

    // Nine CALLs overflow an 8-deep stack; the oldest entry is lost
    for (int i = 0; i < 9; i++) begin
      send(CALLR, 0, 0, 32'h10000 + i * 32'h100, 5, 32'h0);
      chk("callr_eip", next_eip, 32'h10005 + i * 32'h100);
    end
    for (int j = 0; j < 9; j++) begin
      send(RET, 0, 0, 32'h0, 1, 32'h10005 + (8 - j) * 32'h100);
      chk($sformatf("ovf_ret%0d", j), {30'b0, ras_hit, ras_miss}, (j < 8) ? 32'h2 : 32'h1);
    end

    // Stall: result holds, in_ready low, then flush wins over the stall
    send(CALLI, 0, 0, 32'h5000, 5, 32'h6000);
    chk("stall_pre_eip", next_eip, 32'h6000);
    @(negedge clk);
    out_ready = 0; in_valid = 1; opc = JMPI; address = 32'h9999;
    #1 chk("stall_in_ready", {31'b0, in_ready}, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_valid", {31'b0, out_valid}, 1);
      chk("stall_eip", next_eip, 32'h6000);
    end
    flush = 1;
    @(negedge clk);
    flush = 0; in_valid = 0; out_ready = 1;
    chk("flush_stall_valid", {31'b0, out_valid}, 0);
    send(RET, 0, 0, 32'h0, 1, 32'h5005);
    chk("flush_ras_empty", {30'b0, ras_hit, ras_miss}, 32'h1);

    // Flush together with an accept: the CALL is discarded
    @(negedge clk);
    opc = CALLI; eip = 32'h7000; instr_len = 5; address = 32'hA000; in_valid = 1; flush = 1;
    @(negedge clk);
    in_valid = 0; flush = 0;
    chk("flush_acc_valid", {31'b0, out_valid}, 0);
    @(negedge clk);
    chk("flush_acc_idle", {31'b0, out_valid}, 0);
    send(RET, 0, 0, 32'h0, 1, 32'h7005);
    chk("flush_acc_ras", {30'b0, ras_hit, ras_miss}, 32'h1);

    // Reset during a stall drops the pending result at once
    send(MOV, 0, 0, 32'h100, 1, 0);
    @(negedge clk);
    out_ready = 0;
    @(negedge clk);
    chk("pre_rst_valid", {31'b0, out_valid}, 1);
    rst_n = 0;
    #1 chk("mid_rst_valid", {31'b0, out_valid}, 0);
    chk("mid_rst_eip", next_eip, 0);
    @(negedge clk);
    rst_n = 1; out_ready = 1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
